// File: rtl/register_arbiter_pkg.sv
// rtl/register_arbiter_pkg.sv - shared constants and state encoding for register_arbiter
package register_arbiter_pkg;

    localparam int DEFAULT_N     = 4;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    // Pointer width for n requesters; at least one bit so vectors stay legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/register_arbiter_rr_picker.sv
// rtl/register_arbiter_rr_picker.sv - combinational round-robin winner selection
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  winner_o,
    output logic          valid_o
);

    logic [PW-1:0] idx;

    // Scan from ptr_i upward, wrapping at N-1, and take the first active request.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[idx]) begin
                winner_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_arbiter.sv
// rtl/register_arbiter.sv - round-robin arbitrated shared register (option: REGISTER_ARBITER_LOCK_EN)
module register_arbiter
    import register_arbiter_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [N-1:0]         REQ,
    input  logic [N*WIDTH-1:0]   DIN,
`ifdef REGISTER_ARBITER_LOCK_EN
    input  logic [N-1:0]         LOCK,
`endif
    output logic [N-1:0]         GNT,
    output logic [N-1:0]         ACK,
    output logic [WIDTH-1:0]     Q,
    output logic                 BUSY
);

    localparam int PW = ptr_width(N);

    state_e         state_q;
    logic [PW-1:0]  ptr_q;
    logic [PW-1:0]  win_idx_q;
    logic [N-1:0]   win_q;
    logic [N-1:0]   gnt_q;
    logic [N-1:0]   ack_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    logic [N-1:0]   pick_oh;
    logic           pick_valid;
    logic [PW-1:0]  pick_idx;
    logic [PW-1:0]  ptr_d;
    logic [WIDTH-1:0] win_din;
    logic           load;

    rr_picker #(
        .N  (N),
        .PW (PW)
    ) u_picker (
        .req_i    (REQ),
        .ptr_i    (ptr_q),
        .winner_o (pick_oh),
        .valid_o  (pick_valid)
    );

    // Binary index of the picker's one-hot winner.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    // Write data of the latched winner, muxed with constant slice offsets.
    always_comb begin
        win_din = '0;
        for (int i = 0; i < N; i++) begin
            if (win_q[i]) begin
                win_din = DIN[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer after a completed write: one past the winner, or held on the winner when locked.
    always_comb begin
        ptr_d = (win_idx_q == PW'(N - 1)) ? '0 : win_idx_q + 1'b1;
`ifdef REGISTER_ARBITER_LOCK_EN
        if (|(LOCK & win_q)) begin
            ptr_d = win_idx_q;
        end
`endif
    end

    // Write only commits while the winner is still requesting in GRANT.
    assign load = (state_q == ST_GRANT) && |(REQ & win_q);
    assign q_d  = load ? win_din : q_q;

    // Arbitration FSM with registered grant and acknowledge outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            win_idx_q <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= '0;
                    if (pick_valid) begin
                        win_q     <= pick_oh;
                        win_idx_q <= pick_idx;
                        gnt_q     <= pick_oh;
                        state_q   <= ST_GRANT;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                ST_GRANT: begin
                    if (load) begin
                        ack_q   <= win_q;
                        state_q <= ST_ACK;
                    end else begin
                        gnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    ack_q   <= '0;
                    gnt_q   <= '0;
                    ptr_q   <= ptr_d;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ack_q   <= '0;
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Shared load-enabled register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign GNT  = gnt_q;
    assign ACK  = ack_q;
    assign Q    = q_q;
    assign BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_register_arbiter.sv
// tb/tb_register_arbiter.sv - directed vector bench for register_arbiter
module tb_register_arbiter;

    localparam logic [15:0] D0 = 16'h5A5A;
    localparam logic [15:0] D1 = 16'hBEEF;
    localparam logic [15:0] D2 = 16'hC0DE;
    localparam logic [15:0] D3 = 16'h1234;

    logic        CLK;
    logic        RESET_N;
    logic [3:0]  REQ;
    logic [63:0] DIN;
    logic [3:0]  GNT;
    logic [3:0]  ACK;
    logic [15:0] Q;
    logic        BUSY;
`ifdef REGISTER_ARBITER_LOCK_EN
    logic [3:0]  LOCK;
`endif

    int checks;
    int failures;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [15:0] q;
        logic        busy;
    } vec_t;

    vec_t vq[$];

    register_arbiter #(.N(4), .WIDTH(16)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .REQ     (REQ),
        .DIN     (DIN),
`ifdef REGISTER_ARBITER_LOCK_EN
        .LOCK    (LOCK),
`endif
        .GNT     (GNT),
        .ACK     (ACK),
        .Q       (Q),
        .BUSY    (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] req, input logic [3:0] g,
                       input logic [3:0] a, input logic [15:0] q, input logic b);
        vec_t v;
        v.rst_n = r; v.req = req; v.gnt = g; v.ack = a; v.q = q; v.busy = b;
        vq.push_back(v);
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic wait_gnt(output logic [3:0] g);
        g = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            if (GNT != 4'b0 && ACK == 4'b0) begin
                g = GNT;
                break;
            end
        end
    endtask

    initial begin
        int ack_idx[$];
        int ack_cyc[$];
        logic [3:0] g;

        checks   = 0;
        failures = 0;
        RESET_N  = 1'b0;
        REQ      = 4'b0;
        DIN      = {D3, D2, D1, D0};
`ifdef REGISTER_ARBITER_LOCK_EN
        LOCK     = 4'b0;
`endif

        // reset state
        add(0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 0);
        // single request on requester 1
        add(1, 4'b0010, 4'b0010, 4'b0000, 16'h0000, 1);
        add(1, 4'b0010, 4'b0010, 4'b0010, D1, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, D1, 0);
        // reset then round robin 0,1,2,3,0
        add(0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 0);
        add(1, 4'b1111, 4'b0001, 4'b0000, 16'h0000, 1);
        add(1, 4'b1111, 4'b0001, 4'b0001, D0, 1);
        add(1, 4'b1110, 4'b0000, 4'b0000, D0, 0);
        add(1, 4'b1111, 4'b0010, 4'b0000, D0, 1);
        add(1, 4'b1111, 4'b0010, 4'b0010, D1, 1);
        add(1, 4'b1101, 4'b0000, 4'b0000, D1, 0);
        add(1, 4'b1111, 4'b0100, 4'b0000, D1, 1);
        add(1, 4'b1111, 4'b0100, 4'b0100, D2, 1);
        add(1, 4'b1011, 4'b0000, 4'b0000, D2, 0);
        add(1, 4'b1111, 4'b1000, 4'b0000, D2, 1);
        add(1, 4'b1111, 4'b1000, 4'b1000, D3, 1);
        add(1, 4'b0111, 4'b0000, 4'b0000, D3, 0);
        add(1, 4'b1111, 4'b0001, 4'b0000, D3, 1);
        add(1, 4'b1111, 4'b0001, 4'b0001, D0, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, D0, 0);
        // abort on requester 2, pointer stays at 1
        add(1, 4'b0100, 4'b0100, 4'b0000, D0, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, D0, 0);
        add(1, 4'b0011, 4'b0010, 4'b0000, D0, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, D0, 0);
        add(1, 4'b0001, 4'b0001, 4'b0000, D0, 1);
        add(1, 4'b0001, 4'b0001, 4'b0001, D0, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, D0, 0);
        // move pointer to 3, then wrap to requester 0
        add(1, 4'b0100, 4'b0100, 4'b0000, D0, 1);
        add(1, 4'b0100, 4'b0100, 4'b0100, D2, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, D2, 0);
        add(1, 4'b0001, 4'b0001, 4'b0000, D2, 1);
        add(1, 4'b0001, 4'b0001, 4'b0001, D0, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, D0, 0);
        add(1, 4'b0011, 4'b0010, 4'b0000, D0, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, D0, 0);
        // non-winner raised during GRANT is ignored
        add(1, 4'b0001, 4'b0001, 4'b0000, D0, 1);
        add(1, 4'b1001, 4'b0001, 4'b0001, D0, 1);
        add(1, 4'b1000, 4'b0000, 4'b0000, D0, 0);
        add(1, 4'b1000, 4'b1000, 4'b0000, D0, 1);
        add(1, 4'b1000, 4'b1000, 4'b1000, D3, 1);
        add(1, 4'b0000, 4'b0000, 4'b0000, D3, 0);
        // reset in GRANT, then reset in ACK
        add(1, 4'b1000, 4'b1000, 4'b0000, D3, 1);
        add(0, 4'b1000, 4'b0000, 4'b0000, 16'h0000, 0);
        add(1, 4'b1000, 4'b1000, 4'b0000, 16'h0000, 1);
        add(1, 4'b1000, 4'b1000, 4'b1000, D3, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 0);

        for (int i = 0; i < vq.size(); i++) begin
            RESET_N = vq[i].rst_n;
            REQ     = vq[i].req;
            @(posedge CLK); #1;
            chk($sformatf("row%0d GNT", i),  32'(GNT),  32'(vq[i].gnt));
            chk($sformatf("row%0d ACK", i),  32'(ACK),  32'(vq[i].ack));
            chk($sformatf("row%0d Q", i),    32'(Q),    32'(vq[i].q));
            chk($sformatf("row%0d BUSY", i), 32'(BUSY), 32'(vq[i].busy));
        end

        // all four requesting continuously: one write per 3 cycles, fair order
        RESET_N = 1'b0;
        REQ     = 4'b0000;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        REQ     = 4'b1111;
        for (int c = 1; c <= 30; c++) begin
            @(posedge CLK); #1;
            if (ACK != 4'b0) begin
                chk($sformatf("fair onehot c%0d", c), 32'($countones(ACK)), 32'd1);
                ack_idx.push_back(oh2idx(ACK));
                ack_cyc.push_back(c);
            end
        end
        chk("fair ack count", 32'(ack_idx.size()), 32'd10);
        for (int k = 0; k < ack_idx.size(); k++) begin
            chk($sformatf("fair order k%0d", k), 32'(ack_idx[k]), 32'(k % 4));
            chk($sformatf("fair cycle k%0d", k), 32'(ack_cyc[k]), 32'(2 + 3 * k));
        end
        REQ = 4'b0000;
        @(posedge CLK); #1;
        @(posedge CLK); #1;

`ifdef REGISTER_ARBITER_LOCK_EN
        // lock keeps requester 0 winning until released
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        REQ     = 4'b0011;
        LOCK    = 4'b0001;
        wait_gnt(g);
        chk("lock grant1", 32'(g), 32'h1);
        wait_gnt(g);
        chk("lock grant2", 32'(g), 32'h1);
        LOCK = 4'b0000;
        wait_gnt(g);
        chk("lock release grant3", 32'(g), 32'h2);
        REQ = 4'b0000;
`else
        // without lock, a held requester 0 yields to requester 1
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        REQ     = 4'b0011;
        wait_gnt(g);
        chk("rr grant1", 32'(g), 32'h1);
        wait_gnt(g);
        chk("rr grant2", 32'(g), 32'h2);
        REQ = 4'b0000;
`endif
        @(posedge CLK); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
